register_file_scoreboard: RTL and testbench

- Parametrised successor to the CPU's 8x16 register file: configurable data width and register count, explicit write enable, synchronous reset.
- Adds a per-register pending scoreboard. The decode stage marks a destination busy at issue; writeback clears it. Hazard outputs let decode stall.
- Sits between decode (read ports, issue) and writeback (write port, flags).

---
 rtl/register_file_scoreboard.sv | 137 +++++++++++++
 tb/tb_register_file_scoreboard.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_scoreboard.sv
// Parametrised register file with a per-register pending scoreboard for decode stalls.
// Optional macro REGFILE_BYPASS_EN enables write-through forwarding on the read and busy outputs.
module register_file_scoreboard #(
  parameter int DataWidth    = 16,
  parameter int RegCount     = 8,
  parameter int AddrWidth    = $clog2(RegCount),
  parameter int FlagsAddress = RegCount - 1,
  parameter int ZeroReg      = 0
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [AddrWidth-1:0]          AddrB,
  input  logic [AddrWidth-1:0]          AddrC,
  output logic [DataWidth-1:0]          OutDataB,
  output logic [DataWidth-1:0]          OutDataC,
  output logic [DataWidth-1:0]          OutFlags,
  input  logic                          WriteEnable,
  input  logic [AddrWidth-1:0]          AddrA,
  input  logic [DataWidth-1:0]          InDataA,
  input  logic                          UpdateFlags,
  input  logic [DataWidth-1:0]          InNewFlags,
  input  logic                          IssueValid,
  input  logic [AddrWidth-1:0]          IssueAddr,
  input  logic                          IssueFlags,
  output logic                          BusyB,
  output logic                          BusyC,
  output logic                          BusyFlags,
  output logic                          Stall,
  input  logic                          StallQualify,
  output logic [RegCount-1:0]           PendingMask,
  output logic [DataWidth*RegCount-1:0] DebugData
);

  localparam logic [AddrWidth-1:0] FLAGS_IDX = AddrWidth'(FlagsAddress);
  localparam bit ZERO_EN = (ZeroReg != 0);

  typedef logic [DataWidth-1:0] word_t;

  word_t               regs_q [RegCount];
  word_t               regs_d [RegCount];
  logic [RegCount-1:0] pending_q, pending_d;
  logic [RegCount-1:0] set_vec, clr_vec, pend_eff;

  // IssueValid and WriteEnable/UpdateFlags are single-cycle strobes with no
  // back-pressure: each is consumed on the edge where it is high, and decode
  // is expected to hold issue off itself while Stall is asserted.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 0; i < RegCount; i++) begin
      set_vec[i] = IssueValid  & (IssueAddr == AddrWidth'(i));
      clr_vec[i] = WriteEnable & (AddrA     == AddrWidth'(i));
    end
    set_vec[FlagsAddress] = set_vec[FlagsAddress] | (IssueValid & IssueFlags);
    clr_vec[FlagsAddress] = clr_vec[FlagsAddress] | UpdateFlags;
    if (ZERO_EN) begin
      set_vec[0] = 1'b0;
      clr_vec[0] = 1'b0;
    end
  end

  // A fresh issue beats a writeback landing on the same edge.
  always_comb begin
    pending_d = set_vec | (pending_q & ~clr_vec);
  end

  always_comb begin
    regs_d = regs_q;
    if (WriteEnable && !(ZERO_EN && AddrA == '0)) begin
      regs_d[AddrA] = InDataA;
    end
    if (UpdateFlags) begin
      regs_d[FLAGS_IDX] = InNewFlags;
    end
    if (ZERO_EN) begin
      regs_d[0] = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < RegCount; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  function automatic word_t fwd_read(input logic [AddrWidth-1:0] addr);
    word_t v;
    v = regs_q[addr];
    if (!Reset && !(ZERO_EN && addr == '0)) begin
      if (UpdateFlags && addr == FLAGS_IDX) begin
        v = InNewFlags;
      end else if (WriteEnable && addr == AddrA) begin
        v = InDataA;
      end
    end
    return v;
  endfunction

  always_comb begin
    OutDataB = fwd_read(AddrB);
    OutDataC = fwd_read(AddrC);
    OutFlags = fwd_read(FLAGS_IDX);
    pend_eff = Reset ? pending_q : (pending_q & ~(clr_vec & ~set_vec));
  end
`else
  always_comb begin
    OutDataB = regs_q[AddrB];
    OutDataC = regs_q[AddrC];
    OutFlags = regs_q[FLAGS_IDX];
    pend_eff = pending_q;
  end
`endif

  always_comb begin
    BusyB       = pend_eff[AddrB];
    BusyC       = pend_eff[AddrC];
    BusyFlags   = pend_eff[FlagsAddress];
    Stall       = StallQualify & (BusyB | BusyC | BusyFlags);
    PendingMask = pending_q;
  end

  // DebugData always shows committed state, never forwarded values.
  always_comb begin
    DebugData = '0;
    for (int i = 0; i < RegCount; i++) begin
      DebugData[i*DataWidth +: DataWidth] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Scoreboard bench: two instances (ZeroReg=0 and ZeroReg=1) checked against an array-based model.
module tb_register_file_scoreboard;

  localparam int EW = 188;

  typedef struct packed {
    logic        rst;
    logic        we;
    logic [2:0]  aa;
    logic [15:0] da;
    logic        uf;
    logic [15:0] nf;
    logic        iv;
    logic [2:0]  ia;
    logic        ifl;
    logic [2:0]  ab;
    logic [2:0]  ac;
    logic        sq;
  } stim_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [2:0]  AddrB = '0, AddrC = '0, AddrA = '0, IssueAddr = '0;
  logic        WriteEnable = 1'b0, UpdateFlags = 1'b0, IssueValid = 1'b0;
  logic        IssueFlags = 1'b0, StallQualify = 1'b0;
  logic [15:0] InDataA = '0, InNewFlags = '0;

  logic [15:0]  ob0, oc0, of0, ob1, oc1, of1;
  logic         bb0, bc0, bf0, st0, bb1, bc1, bf1, st1;
  logic [7:0]   pm0, pm1;
  logic [127:0] dd0, dd1;

  logic [2*EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_regs [2][8];
  bit          m_pend [2][8];

  always #5 Clk = ~Clk;

  register_file_scoreboard dut0 (
    .Clk(Clk), .Reset(Reset), .AddrB(AddrB), .AddrC(AddrC),
    .OutDataB(ob0), .OutDataC(oc0), .OutFlags(of0),
    .WriteEnable(WriteEnable), .AddrA(AddrA), .InDataA(InDataA),
    .UpdateFlags(UpdateFlags), .InNewFlags(InNewFlags),
    .IssueValid(IssueValid), .IssueAddr(IssueAddr), .IssueFlags(IssueFlags),
    .BusyB(bb0), .BusyC(bc0), .BusyFlags(bf0), .Stall(st0),
    .StallQualify(StallQualify), .PendingMask(pm0), .DebugData(dd0)
  );

  register_file_scoreboard #(.ZeroReg(1)) dutz (
    .Clk(Clk), .Reset(Reset), .AddrB(AddrB), .AddrC(AddrC),
    .OutDataB(ob1), .OutDataC(oc1), .OutFlags(of1),
    .WriteEnable(WriteEnable), .AddrA(AddrA), .InDataA(InDataA),
    .UpdateFlags(UpdateFlags), .InNewFlags(InNewFlags),
    .IssueValid(IssueValid), .IssueAddr(IssueAddr), .IssueFlags(IssueFlags),
    .BusyB(bb1), .BusyC(bc1), .BusyFlags(bf1), .Stall(st1),
    .StallQualify(StallQualify), .PendingMask(pm1), .DebugData(dd1)
  );

  // ---------------- reference model ----------------
  function automatic logic [15:0] m_read(input int k, input int addr);
    logic [15:0] v;
    v = m_regs[k][addr];
`ifdef REGFILE_BYPASS_EN
    if (!Reset && !(k == 1 && addr == 0)) begin
      if (UpdateFlags && addr == 7) v = InNewFlags;
      else if (WriteEnable && addr == int'(AddrA)) v = InDataA;
    end
`endif
    return v;
  endfunction

  function automatic logic m_busy(input int k, input int addr);
    logic b;
    b = m_pend[k][addr];
`ifdef REGFILE_BYPASS_EN
    if (!Reset) begin
      if (((WriteEnable && addr == int'(AddrA)) || (UpdateFlags && addr == 7)) &&
          !((IssueValid && addr == int'(IssueAddr)) || (IssueValid && IssueFlags && addr == 7)))
        b = 1'b0;
    end
`endif
    return b;
  endfunction

  function automatic logic [EW-1:0] m_expect(input int k);
    logic [15:0]  eb, ec, ef;
    logic         xb, xc, xf;
    logic [7:0]   pm;
    logic [127:0] dbg;
    eb = m_read(k, int'(AddrB));
    ec = m_read(k, int'(AddrC));
    ef = m_read(k, 7);
    xb = m_busy(k, int'(AddrB));
    xc = m_busy(k, int'(AddrC));
    xf = m_busy(k, 7);
    for (int i = 0; i < 8; i++) begin
      pm[i] = m_pend[k][i];
      dbg[i*16 +: 16] = m_regs[k][i];
    end
    return {eb, ec, ef, xb, xc, xf, StallQualify & (xb | xc | xf), pm, dbg};
  endfunction

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (Reset) begin
        for (int i = 0; i < 8; i++) begin
          m_regs[k][i] = '0;
          m_pend[k][i] = 1'b0;
        end
      end else begin
        if (WriteEnable && !(k == 1 && AddrA == 3'd0)) m_regs[k][AddrA] = InDataA;
        if (UpdateFlags) m_regs[k][7] = InNewFlags;
        if (WriteEnable) m_pend[k][AddrA] = 1'b0;
        if (UpdateFlags) m_pend[k][7] = 1'b0;
        if (IssueValid) m_pend[k][IssueAddr] = 1'b1;
        if (IssueValid && IssueFlags) m_pend[k][7] = 1'b1;
        if (k == 1) m_pend[k][0] = 1'b0;
      end
    end
  endtask

  // ---------------- driver ----------------
  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    @(posedge Clk);
    model_update();
    #1;
    Reset = s.rst;  WriteEnable = s.we; AddrA = s.aa; InDataA = s.da;
    UpdateFlags = s.uf; InNewFlags = s.nf; IssueValid = s.iv; IssueAddr = s.ia;
    IssueFlags = s.ifl; AddrB = s.ab; AddrC = s.ac; StallQualify = s.sq;
    #0;
    exp_q.push_back({m_expect(0), m_expect(1)});
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic compare_one(input string tag, input logic [EW-1:0] e, input logic [EW-1:0] a);
    check({tag, ".OutDataB"},    128'(a[187:172]), 128'(e[187:172]));
    check({tag, ".OutDataC"},    128'(a[171:156]), 128'(e[171:156]));
    check({tag, ".OutFlags"},    128'(a[155:140]), 128'(e[155:140]));
    check({tag, ".BusyB"},       128'(a[139]),     128'(e[139]));
    check({tag, ".BusyC"},       128'(a[138]),     128'(e[138]));
    check({tag, ".BusyFlags"},   128'(a[137]),     128'(e[137]));
    check({tag, ".Stall"},       128'(a[136]),     128'(e[136]));
    check({tag, ".PendingMask"}, 128'(a[135:128]), 128'(e[135:128]));
    check({tag, ".DebugData"},   a[127:0],         e[127:0]);
  endtask

  always @(negedge Clk) begin
    logic [2*EW-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      compare_one("d0", e[2*EW-1:EW], {ob0, oc0, of0, bb0, bc0, bf0, st0, pm0, dd0});
      compare_one("dz", e[EW-1:0],    {ob1, oc1, of1, bb1, bc1, bf1, st1, pm1, dd1});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) begin
        m_regs[k][i] = '0;
        m_pend[k][i] = 1'b0;
      end

    s = idle(); s.rst = 1'b1; drive(s); drive(s);
    for (int i = 0; i < 8; i++) begin
      s = idle(); s.ab = 3'(i); s.ac = 3'(7 - i); s.sq = 1'b1; drive(s);
    end

    s = idle(); s.we = 1; s.aa = 3; s.da = 16'hBEEF; s.ab = 3; drive(s);
    s = idle(); s.ab = 3; drive(s);

    s = idle(); s.we = 1; s.aa = 7; s.da = 16'h1111; s.uf = 1; s.nf = 16'h0005; drive(s);
    s = idle(); s.ab = 7; drive(s);

    s = idle(); s.iv = 1; s.ia = 2; drive(s);
    s = idle(); s.ab = 2; s.sq = 1; drive(s);
    s = idle(); s.we = 1; s.aa = 2; s.da = 16'h00AA; s.ab = 2; s.sq = 1; drive(s);
    s = idle(); s.ab = 2; s.sq = 1; drive(s);

    s = idle(); s.iv = 1; s.ia = 5; s.we = 1; s.aa = 5; s.da = 16'h5555; drive(s);
    s = idle(); s.ab = 5; s.sq = 1; drive(s);
    s = idle(); s.iv = 1; s.ia = 1; s.ifl = 1; drive(s);
    s = idle(); s.sq = 1; drive(s);
    s = idle(); s.uf = 1; s.nf = 16'h0009; s.sq = 1; drive(s);
    s = idle(); s.sq = 1; drive(s);

    s = idle(); s.we = 1; s.aa = 0; s.da = 16'hFFFF; drive(s);
    s = idle(); s.iv = 1; s.ia = 0; drive(s);
    s = idle(); s.ab = 0; s.ac = 0; s.sq = 1; drive(s);

    s = idle(); s.we = 1; s.aa = 4; s.da = 16'h1234; s.ac = 4; drive(s);
    s = idle(); s.ac = 4; drive(s);

    s = idle(); s.iv = 1; s.ia = 1; s.ifl = 1; drive(s);
    s = idle(); s.rst = 1; s.ab = 1; s.sq = 1; drive(s);
    s = idle(); s.ab = 1; s.sq = 1; drive(s);
    s = idle(); s.we = 1; s.aa = 1; s.da = 16'h0042; s.ab = 1; drive(s);
    s = idle(); s.ab = 1; s.sq = 1; drive(s);

    for (int n = 0; n < 400; n++) begin
      s.rst = ($urandom_range(0, 39) == 0);
      s.we  = 1'($urandom_range(0, 1));
      s.aa  = 3'($urandom_range(0, 7));
      s.da  = 16'($urandom);
      s.uf  = ($urandom_range(0, 3) == 0);
      s.nf  = 16'($urandom);
      s.iv  = 1'($urandom_range(0, 1));
      s.ia  = 3'($urandom_range(0, 7));
      s.ifl = ($urandom_range(0, 3) == 0);
      s.ab  = 3'($urandom_range(0, 7));
      s.ac  = 3'($urandom_range(0, 7));
      s.sq  = 1'($urandom_range(0, 1));
      drive(s);
    end

    @(negedge Clk);
    @(negedge Clk);
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
